spi_byte_phy: RTL and testbench



---
 rtl/spi_byte_phy.sv | 173 +++++++++++++++++
 tb/tb_spi_byte_phy.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_phy.sv
// spi_byte_phy: SPI mode-0 (CPOL=0, CPHA=0) slave front end.
// Oversamples the raw SPI pins in the clk domain and exchanges whole bytes
// with the register logic through rx_valid / tx_load / frame_start / frame_end.
// Optional build macro: SPI_BYTE_PHY_GLITCH_FILTER_EN adds a 3-sample majority
// filter on synchronised spi_clk and spi_cs (two extra cycles of edge latency).
module spi_byte_phy #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       frame_start,
    output logic       frame_end
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic       sck_lvl, cs_lvl, mosi_s;
    logic       sck_d, cs_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       start_evt, end_evt, rx_evt, reload_evt, shift_evt;
    logic [2:0] bit_cnt;
    logic       byte_seen, rx_done;
    logic [7:0] rx_shift, tx_shift;
    logic       tx_bit;

    // Input synchronisers; cs resets to 0 so a frame already in progress is not mistaken for a new one
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
        end
    end

`ifdef SPI_BYTE_PHY_GLITCH_FILTER_EN
    logic [2:0] sck_win, cs_win;

    // Three-sample history windows feeding the majority vote
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_win <= '0;
            cs_win  <= '0;
        end else begin
            sck_win <= {sck_win[1:0], sck_sync[SYNC_STAGES-1]};
            cs_win  <= {cs_win[1:0], cs_sync[SYNC_STAGES-1]};
        end
    end

    assign sck_lvl = (sck_win[0] & sck_win[1]) | (sck_win[0] & sck_win[2]) | (sck_win[1] & sck_win[2]);
    assign cs_lvl  = (cs_win[0] & cs_win[1]) | (cs_win[0] & cs_win[2]) | (cs_win[1] & cs_win[2]);
`else
    assign sck_lvl = sck_sync[SYNC_STAGES-1];
    assign cs_lvl  = cs_sync[SYNC_STAGES-1];
`endif

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // History flops for single-cycle edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_d <= sck_lvl;
            cs_d  <= cs_lvl;
        end
    end

    assign sck_rise = sck_lvl & ~sck_d;
    assign sck_fall = ~sck_lvl & sck_d;
    assign cs_rise  = cs_lvl & ~cs_d;
    assign cs_fall  = ~cs_lvl & cs_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        unique case (state)
            WAIT_IDLE: if (cs_lvl)  state_nxt = IDLE;
            IDLE:      if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:    if (cs_rise) state_nxt = IDLE;
            default:   state_nxt = WAIT_IDLE;
        endcase
    end

    // Event decode; cs_rise masks any SCK edge seen in the same cycle
    always_comb begin
        start_evt  = (state == IDLE) && cs_fall;
        end_evt    = (state == ACTIVE) && cs_rise;
        rx_evt     = (state == ACTIVE) && sck_rise && !cs_rise;
        reload_evt = (state == ACTIVE) && sck_fall && !cs_rise && (bit_cnt == 3'd0) && byte_seen;
        shift_evt  = (state == ACTIVE) && sck_fall && !cs_rise && !reload_evt;
    end

    assign tx_bit      = MSB_FIRST ? tx_shift[7] : tx_shift[0];
    assign spi_miso_oe = (state == ACTIVE);

    // Shift registers, bit counter and strobes; tx_data is sampled on the edge that raises tx_load
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift    <= '0;
            tx_shift    <= '0;
            bit_cnt     <= '0;
            byte_seen   <= 1'b0;
            rx_done     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            spi_miso    <= 1'b0;
        end else begin
            frame_start <= start_evt;
            frame_end   <= end_evt;
            tx_load     <= start_evt | reload_evt;
            rx_done     <= 1'b0;
            rx_valid    <= rx_done;
            if (rx_done) rx_data <= rx_shift;

            if (start_evt) begin
                tx_shift  <= tx_data;
                bit_cnt   <= '0;
                byte_seen <= 1'b0;
            end else if (end_evt) begin
                bit_cnt <= '0;
            end else begin
                if (rx_evt) begin
                    rx_shift <= MSB_FIRST ? {rx_shift[6:0], mosi_s} : {mosi_s, rx_shift[7:1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_done   <= 1'b1;
                        byte_seen <= 1'b1;
                    end
                end
                if (reload_evt)     tx_shift <= tx_data;
                else if (shift_evt) tx_shift <= MSB_FIRST ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
            end

            spi_miso <= (state_nxt == ACTIVE) ? tx_bit : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_byte_phy.sv
// tb_spi_byte_phy: drives an SPI mode-0 master against an MSB-first and an
// LSB-first instance sharing the same pins, and compares received bytes,
// MISO bytes, strobe counts and rx latency with a byte-level model.
`timescale 1ns/1ps
module tb_spi_byte_phy;

    localparam int SS = 2;
`ifdef SPI_BYTE_PHY_GLITCH_FILTER_EN
    localparam int FILT = 2;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT      = SS + 2 + FILT;
    localparam int MIN_HALF = SS + 2 + FILT;

    logic       clk = 1'b0, rst = 1'b1;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
    logic [7:0] tx_data = 8'h00;

    logic       miso_m, oe_m, rxv_m, txl_m, fs_m, fe_m;
    logic       miso_l, oe_l, rxv_l, txl_l, fs_l, fe_l;
    logic [7:0] rxd_m, rxd_l;

    spi_byte_phy #(.SYNC_STAGES(SS), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .spi_miso(miso_m), .spi_miso_oe(oe_m), .rx_data(rxd_m), .rx_valid(rxv_m),
        .tx_data(tx_data), .tx_load(txl_m), .frame_start(fs_m), .frame_end(fe_m)
    );

    spi_byte_phy #(.SYNC_STAGES(SS), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .spi_miso(miso_l), .spi_miso_oe(oe_l), .rx_data(rxd_l), .rx_valid(rxv_l),
        .tx_data(tx_data), .tx_load(txl_l), .frame_start(fs_l), .frame_end(fe_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and received-byte logs
    int n_fs_m = 0, n_fe_m = 0, n_tl_m = 0;
    int n_fs_l = 0, n_fe_l = 0, n_tl_l = 0;
    logic [7:0] rxq_m[$];
    logic [7:0] rxq_l[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (fs_m)  n_fs_m++;
            if (fe_m)  n_fe_m++;
            if (txl_m) n_tl_m++;
            if (fs_l)  n_fs_l++;
            if (fe_l)  n_fe_l++;
            if (txl_l) n_tl_l++;
            if (rxv_m) rxq_m.push_back(rxd_m);
            if (rxv_l) rxq_l.push_back(rxd_l);
        end
    end

    bit         bit_q[$];
    logic [7:0] tx_list[8];
    int         glitch_at = -1;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit msb);
        for (int j = 0; j < 8; j++) bit_q.push_back(msb ? b[7-j] : b[j]);
    endtask

    // Byte k of the MOSI stream as seen by a slave with the given bit order
    function automatic logic [7:0] model_byte(input int k, input bit msb);
        int v = 0;
        for (int j = 0; j < 8; j++) begin
            if (msb) v = v * 2 + int'(bit_q[8*k+j]);
            else     v = v + (int'(bit_q[8*k+j]) << j);
        end
        return v[7:0];
    endfunction

    // Reassemble MISO samples the way a master of the given bit order would
    function automatic logic [7:0] master_byte(input bit s[$], input int k, input bit msb);
        int v = 0;
        for (int j = 0; j < 8; j++) begin
            if (msb) v = v * 2 + int'(s[8*k+j]);
            else     v = v + (int'(s[8*k+j]) << j);
        end
        return v[7:0];
    endfunction

    task automatic run_frame(input string tag, input int half);
        int nbits = bit_q.size();
        int nbytes = nbits / 8;
        int b_fs_m = n_fs_m, b_fe_m = n_fe_m, b_tl_m = n_tl_m;
        int b_fs_l = n_fs_l, b_fe_l = n_fe_l, b_tl_l = n_tl_l;
        int q_m = rxq_m.size(), q_l = rxq_l.size();
        int oe_bad = 0;
        int lat;
        bit sm[$];
        bit sl[$];

        tx_data = tx_list[0];
        wait_clk(2);
        spi_cs = 1'b0;
        wait_clk(SS + 6 + FILT);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bit_q[i];
            if (i == glitch_at) begin
                wait_clk(2);
                spi_clk = 1'b1;
                wait_clk(1);
                spi_clk = 1'b0;
                wait_clk(half - 3);
            end else begin
                wait_clk(half);
            end
            sm.push_back(miso_m);
            sl.push_back(miso_l);
            if (!(oe_m && oe_l)) oe_bad++;
            spi_clk = 1'b1;
            lat = -1;
            for (int c = 1; c <= half; c++) begin
                wait_clk(1);
                if (rxv_m && lat < 0) lat = c;
            end
            if (i % 8 == 7) begin
                check($sformatf("%s_lat%0d", tag, i / 8), lat, LAT);
                tx_data = tx_list[i/8+1];
            end
            spi_clk = 1'b0;
        end
        wait_clk(half);
        spi_cs = 1'b1;
        wait_clk(SS + 8 + FILT);

        check({tag, "_fs_m"}, n_fs_m - b_fs_m, 1);
        check({tag, "_fs_l"}, n_fs_l - b_fs_l, 1);
        check({tag, "_fe_m"}, n_fe_m - b_fe_m, 1);
        check({tag, "_fe_l"}, n_fe_l - b_fe_l, 1);
        check({tag, "_txload_m"}, n_tl_m - b_tl_m, 1 + nbytes);
        check({tag, "_txload_l"}, n_tl_l - b_tl_l, 1 + nbytes);
        check({tag, "_rxcnt_m"}, rxq_m.size() - q_m, nbytes);
        check({tag, "_rxcnt_l"}, rxq_l.size() - q_l, nbytes);
        for (int k = 0; k < nbytes; k++) begin
            if (q_m + k < rxq_m.size())
                check($sformatf("%s_rx_m%0d", tag, k), rxq_m[q_m+k], model_byte(k, 1'b1));
            if (q_l + k < rxq_l.size())
                check($sformatf("%s_rx_l%0d", tag, k), rxq_l[q_l+k], model_byte(k, 1'b0));
            check($sformatf("%s_miso_m%0d", tag, k), master_byte(sm, k, 1'b1), tx_list[k]);
            check($sformatf("%s_miso_l%0d", tag, k), master_byte(sl, k, 1'b0), tx_list[k]);
        end
        check({tag, "_oe_in_frame"}, oe_bad, 0);
        check({tag, "_idle_pins"}, {oe_m, oe_l, miso_m, miso_l}, 0);
    endtask

    task automatic clock_bits(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            wait_clk(half);
            spi_clk = 1'b1;
            wait_clk(half);
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        int b_fs, b_tl, b_fe, b_rx;

        rst = 1'b1;
        wait_clk(4);
        check("rst_outs_m", {rxd_m, rxv_m, miso_m, oe_m, txl_m, fs_m, fe_m}, 0);
        check("rst_outs_l", {rxd_l, rxv_l, miso_l, oe_l, txl_l, fs_l, fe_l}, 0);
        rst = 1'b0;
        wait_clk(10);

        // Single byte 0xA5 with MISO byte 0x3C
        bit_q.delete();
        push_byte(8'hA5, 1'b1);
        tx_list[0] = 8'h3C; tx_list[1] = 8'h00;
        run_frame("a5", 8);

        // Three-byte stream with tx_data refreshed after each byte
        bit_q.delete();
        push_byte(8'h01, 1'b1); push_byte(8'h80, 1'b1); push_byte(8'hFF, 1'b1);
        tx_list[0] = 8'h3C; tx_list[1] = 8'h11; tx_list[2] = 8'h22; tx_list[3] = 8'h33;
        run_frame("stream", 8);

        // Partial byte discarded, then counter restarts
        bit_q.delete();
        for (int i = 0; i < 5; i++) bit_q.push_back(1'b1);
        tx_list[0] = 8'h96;
        run_frame("partial", 8);
        bit_q.delete();
        push_byte(8'h5A, 1'b1);
        tx_list[0] = 8'hE7; tx_list[1] = 8'h00;
        run_frame("after_partial", 8);

        // Reset in the middle of a frame
        spi_cs = 1'b0;
        wait_clk(SS + 6 + FILT);
        clock_bits(3, 6);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_oe", {oe_m, oe_l}, 0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        b_fs = n_fs_m + n_fs_l; b_tl = n_tl_m + n_tl_l; b_fe = n_fe_m + n_fe_l;
        b_rx = rxq_m.size() + rxq_l.size();
        clock_bits(10, 6);
        check("rst_mid_fs", n_fs_m + n_fs_l - b_fs, 0);
        check("rst_mid_txload", n_tl_m + n_tl_l - b_tl, 0);
        check("rst_mid_rx", rxq_m.size() + rxq_l.size() - b_rx, 0);
        check("rst_mid_oe_after", {oe_m, oe_l, miso_m, miso_l}, 0);
        spi_cs = 1'b1;
        wait_clk(10);
        check("rst_mid_fe", n_fe_m + n_fe_l - b_fe, 0);
        bit_q.delete();
        push_byte(8'hC3, 1'b1);
        tx_list[0] = 8'h5E; tx_list[1] = 8'h00;
        run_frame("after_rst", 8);

        // LSB-first master sending 0x01
        bit_q.delete();
        push_byte(8'h01, 1'b0);
        tx_list[0] = 8'hA1; tx_list[1] = 8'h00;
        run_frame("lsb01", 8);

`ifdef SPI_BYTE_PHY_GLITCH_FILTER_EN
        // Single-cycle spi_clk glitch during a low phase must not shift a bit
        bit_q.delete();
        push_byte(8'h6D, 1'b1);
        tx_list[0] = 8'h4B; tx_list[1] = 8'h00;
        glitch_at = 3;
        run_frame("glitch", 8);
        glitch_at = -1;
`endif

        // Randomised frames, including trailing partial bits and minimum phases
        for (int f = 0; f < 6; f++) begin
            int nb = $urandom_range(1, 3);
            int extra = $urandom_range(0, 3);
            bit_q.delete();
            for (int k = 0; k < nb; k++) push_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < extra; k++) bit_q.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < 8; k++) tx_list[k] = 8'($urandom_range(0, 255));
            run_frame($sformatf("rnd%0d", f), $urandom_range(MIN_HALF, MIN_HALF + 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
